screen_state_mux: RTL and testbench
===================================

Name: screen_state_mux

Overview:
- Top-level screen sequencer and final pixel mux that sits directly downstream of the start screen mux.
- Consumes the combined start-screen pixel stream (RGB plus drawing request), the in-game pixel stream and the game-over overlay stream.
- Tracks the game phase (START / GAME / GAME_OVER) using the start key and game events, then drives the single registered RGB output toward the VGA controller.
- Also drives the game-logic reset that holds the invaders, player and shots idle outside the GAME phase.

Parameters:
- START_LOCKOUT_FRAMES, 30, frames after entering START during which the start key is ignored (1..255).
- GAME_OVER_FRAMES, 180, frames the game-over overlay stays up before returning to START (1..255).

Ports:
- clk  in  1  pixel clock.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-cycle pulse, once per frame.
- startKey  in  1  raw start key level, 1 = pressed, asynchronous to clk.
- playerDead  in  1  one-cycle pulse; game lost.
- invadersReachedBottom  in  1  one-cycle pulse; game lost.
- startScreenDR  in  1  start screen drawing request.
- startScreenRGB  in  8  start screen pixel.
- gameDR  in  1  in-game objects drawing request.
- gameRGB  in  8  in-game pixel.
- gameOverDR  in  1  game-over text drawing request.
- gameOverRGB  in  8  game-over text pixel.
- backgroundRGB  in  8  background pixel.
- RGBOut  out  8  final pixel to VGA.
- gameResetN  out  1  active-low reset for game logic; low outside GAME.
- gameActive  out  1  1 while in GAME.
- screenState  out  2  00 START, 01 GAME, 10 GAME_OVER.

Behaviour:
- Reset (async, resetN=0): state=START, frameCnt=0, key sync flops=0, keyPrev=0, RGBOut=8'h00, gameResetN=0, gameActive=0, screenState=2'b00.
- Key input: 2-flop synchronizer on startKey, then rising-edge detect (keyRise = sync & ~keyPrev). A held key produces exactly one keyRise.
- gameLost = playerDead | invadersReachedBottom.
- frameCnt (8 bit):
  - Cleared to 0 on the cycle of any state transition.
  - Otherwise increments on startOfFrame and saturates at 255.
- START state:
  - Go to GAME when keyRise=1 and frameCnt >= START_LOCKOUT_FRAMES.
  - A keyRise during lockout is discarded; it is not queued.
- GAME state:
  - Go to GAME_OVER when gameLost=1.
  - keyRise is ignored.
  - If gameLost and keyRise occur in the same cycle, gameLost wins.
- GAME_OVER state:
  - Go to START when startOfFrame=1 and frameCnt == GAME_OVER_FRAMES-1, i.e. after exactly GAME_OVER_FRAMES frame pulses.
  - keyRise and gameLost are ignored.
- Encoding 2'b11 is illegal and recovers to START on the next clock.
- Registered outputs (1-cycle latency, registered from next-state): gameActive = (next==GAME); gameResetN = (next==GAME); screenState = next.
  - The START->GAME transition therefore raises gameResetN on the same edge the state register updates.
- Pixel mux: selected by the current state register, registered, 1-cycle latency from the DR/RGB inputs to RGBOut.
  - START: startScreenDR ? startScreenRGB : backgroundRGB.
  - GAME: gameDR ? gameRGB : backgroundRGB. startScreenDR and gameOverDR are ignored.
  - GAME_OVER: gameOverDR ? gameOverRGB : (gameDR ? gameRGB : backgroundRGB). The overlay sits on top of the frozen game.
  - Illegal state: 8'h00.
- Mid-frame transitions take effect immediately at pixel level; no frame alignment is required.
- Reset mid-operation returns to START immediately, with outputs at their reset values. Lockout restarts from 0 after reset.

Test Plan:
1. Reset, then key press at frame 5 -> stays START, gameResetN=0. Release, then press again at frame 31 -> screenState=01, gameActive=1, gameResetN=1 one clock after the synchronized edge.
2. In START with startScreenDR=1, startScreenRGB=8'hE0, backgroundRGB=8'h03 -> RGBOut=8'hE0 one cycle later. Drop DR -> RGBOut=8'h03. gameDR=1 with gameRGB=8'h1C -> still 8'h03.
3. In GAME, hold startKey high for 100 frames -> no state change. Then playerDead and keyRise in the same cycle -> screenState=10, gameResetN=0.
4. In GAME_OVER with gameOverDR=1, gameOverRGB=8'hFF, gameDR=1, gameRGB=8'h1C -> RGBOut=8'hFF. gameOverDR=0 -> 8'h1C.
5. GAME_OVER_FRAMES=4 -> exactly 4 startOfFrame pulses return to START (screenState=00). A press 1 frame later is ignored due to lockout.
6. Assert resetN=0 mid-GAME, asynchronously between clock edges -> RGBOut=00, gameActive=0, gameResetN=0, screenState=00 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/screen_state_mux.sv
// ---------------------------------------------------------------------------
// screen_state_mux
//
// Top-level screen sequencer and final pixel mux. Tracks the game phase
// (START / GAME / GAME_OVER) from the start key and the game-lost events,
// and drives the registered pixel output toward the VGA controller.
//
// The three layers are selected as follows:
//   START     : start screen over background
//   GAME      : game objects over background
//   GAME_OVER : game-over text over the frozen game, over background
//
// Ports:
//   clk                    pixel clock
//   resetN                 asynchronous active-low reset
//   startOfFrame           one-cycle pulse once per frame
//   startKey               raw start key level (asynchronous to clk)
//   playerDead             one-cycle pulse, game lost
//   invadersReachedBottom  one-cycle pulse, game lost
//   startScreenDR/RGB      start screen drawing request / pixel
//   gameDR/RGB             in-game objects drawing request / pixel
//   gameOverDR/RGB         game-over text drawing request / pixel
//   backgroundRGB          background pixel
//   RGBOut                 registered final pixel
//   gameResetN             active-low reset for game logic, low outside GAME
//   gameActive             1 while in GAME
//   screenState            phase: 00 START, 01 GAME, 10 GAME_OVER
//                          (registered copy of the state, usable as a debug
//                          view of the FSM)
// ---------------------------------------------------------------------------
module screen_state_mux #(
  parameter int START_LOCKOUT_FRAMES = 30,
  parameter int GAME_OVER_FRAMES     = 180
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       startKey,
  input  logic       playerDead,
  input  logic       invadersReachedBottom,
  input  logic       startScreenDR,
  input  logic [7:0] startScreenRGB,
  input  logic       gameDR,
  input  logic [7:0] gameRGB,
  input  logic       gameOverDR,
  input  logic [7:0] gameOverRGB,
  input  logic [7:0] backgroundRGB,
  output logic [7:0] RGBOut,
  output logic       gameResetN,
  output logic       gameActive,
  output logic [1:0] screenState
);

  typedef enum logic [1:0] {
    S_START = 2'b00,
    S_GAME  = 2'b01,
    S_OVER  = 2'b10
  } state_t;

  localparam logic [7:0] LOCKOUT   = 8'(START_LOCKOUT_FRAMES);
  localparam logic [7:0] OVER_LAST = 8'(GAME_OVER_FRAMES - 1);

  state_t     state;
  state_t     nextState;
  logic [7:0] frameCnt;
  logic       keySync1;
  logic       keySync2;
  logic       keyPrev;
  logic       keyRise;
  logic       gameLost;
  logic [7:0] pixelNext;

  // A held key gives a single rise because keyPrev follows the synced level.
  assign keyRise  = keySync2 & ~keyPrev;
  assign gameLost = playerDead | invadersReachedBottom;

  // Next-state decision. Events that are irrelevant to a phase are simply
  // not looked at there; a key press during lockout is dropped, not queued.
  always_comb begin
    nextState = state;
    case (state)
      S_START: begin
        if (keyRise && (frameCnt >= LOCKOUT)) nextState = S_GAME;
      end
      S_GAME: begin
        if (gameLost) nextState = S_OVER;
      end
      S_OVER: begin
        if (startOfFrame && (frameCnt == OVER_LAST)) nextState = S_START;
      end
      default: nextState = S_START;
    endcase
  end

  // Pixel selection follows the current state, not the next one, so a
  // mid-frame transition switches layers one cycle after the state edge.
  always_comb begin
    pixelNext = 8'h00;
    case (state)
      S_START: pixelNext = startScreenDR ? startScreenRGB : backgroundRGB;
      S_GAME:  pixelNext = gameDR ? gameRGB : backgroundRGB;
      S_OVER: begin
        if (gameOverDR)  pixelNext = gameOverRGB;
        else if (gameDR) pixelNext = gameRGB;
        else             pixelNext = backgroundRGB;
      end
      default: pixelNext = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= S_START;
      frameCnt    <= 8'd0;
      keySync1    <= 1'b0;
      keySync2    <= 1'b0;
      keyPrev     <= 1'b0;
      RGBOut      <= 8'h00;
      gameResetN  <= 1'b0;
      gameActive  <= 1'b0;
      screenState <= 2'b00;
    end else begin
      keySync1 <= startKey;
      keySync2 <= keySync1;
      keyPrev  <= keySync2;

      state <= nextState;

      // The frame counter restarts on every phase change so each phase
      // measures its own dwell time; it saturates rather than wrapping.
      if (nextState != state) begin
        frameCnt <= 8'd0;
      end else if (startOfFrame && (frameCnt != 8'hFF)) begin
        frameCnt <= frameCnt + 8'd1;
      end

      // Registered from next-state so the game reset releases on the same
      // edge the state register enters GAME.
      gameActive  <= (nextState == S_GAME);
      gameResetN  <= (nextState == S_GAME);
      screenState <= nextState;

      RGBOut <= pixelNext;
    end
  end

endmodule

// File: tb/tb_screen_state_mux.sv
// ---------------------------------------------------------------------------
// tb_screen_state_mux
//
// Directed bench for screen_state_mux. Inputs change 1 time unit after the
// rising clock edge; outputs are observed at that same point, i.e. after the
// edge has settled. GAME_OVER_FRAMES is reduced to 4 to keep runs short.
// ---------------------------------------------------------------------------
module tb_screen_state_mux;

  logic       clk;
  logic       resetN;
  logic       startOfFrame;
  logic       startKey;
  logic       playerDead;
  logic       invadersReachedBottom;
  logic       startScreenDR;
  logic [7:0] startScreenRGB;
  logic       gameDR;
  logic [7:0] gameRGB;
  logic       gameOverDR;
  logic [7:0] gameOverRGB;
  logic [7:0] backgroundRGB;
  logic [7:0] RGBOut;
  logic       gameResetN;
  logic       gameActive;
  logic [1:0] screenState;

  int num_checks = 0;
  int num_fail   = 0;

  logic [7:0] exp_q[$];

  screen_state_mux #(
    .START_LOCKOUT_FRAMES(30),
    .GAME_OVER_FRAMES    (4)
  ) dut (
    .clk                  (clk),
    .resetN               (resetN),
    .startOfFrame         (startOfFrame),
    .startKey             (startKey),
    .playerDead           (playerDead),
    .invadersReachedBottom(invadersReachedBottom),
    .startScreenDR        (startScreenDR),
    .startScreenRGB       (startScreenRGB),
    .gameDR               (gameDR),
    .gameRGB              (gameRGB),
    .gameOverDR           (gameOverDR),
    .gameOverRGB          (gameOverRGB),
    .backgroundRGB        (backgroundRGB),
    .RGBOut               (RGBOut),
    .gameResetN           (gameResetN),
    .gameActive           (gameActive),
    .screenState          (screenState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] st, input logic act);
    check({tag, ".state"}, 8'(screenState), 8'(st));
    check({tag, ".active"}, 8'(gameActive), 8'(act));
    check({tag, ".gameResetN"}, 8'(gameResetN), 8'(act));
  endtask

  // drivers
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      startOfFrame = 1'b1;
      step(1);
      startOfFrame = 1'b0;
      step(2);
    end
  endtask

  // Press: 2 sync edges, then the edge that acts on keyRise.
  task automatic press_key();
    startKey = 1'b1;
    step(3);
  endtask

  task automatic release_key();
    startKey = 1'b0;
    step(3);
  endtask

  task automatic set_pix(input logic sdr, input logic [7:0] srgb,
                         input logic gdr, input logic [7:0] grgb,
                         input logic odr, input logic [7:0] orgb,
                         input logic [7:0] exp);
    startScreenDR  = sdr;
    startScreenRGB = srgb;
    gameDR         = gdr;
    gameRGB        = grgb;
    gameOverDR     = odr;
    gameOverRGB    = orgb;
    exp_q.push_back(exp);
    step(1);
    check("pixel", RGBOut, exp_q.pop_front());
  endtask

  initial begin
    resetN                = 1'b1;
    startOfFrame          = 1'b0;
    startKey              = 1'b0;
    playerDead            = 1'b0;
    invadersReachedBottom = 1'b0;
    startScreenDR         = 1'b0;
    startScreenRGB        = 8'h00;
    gameDR                = 1'b0;
    gameRGB               = 8'h00;
    gameOverDR            = 1'b0;
    gameOverRGB           = 8'h00;
    backgroundRGB         = 8'h03;
    #1 resetN = 1'b0;
    #2;
    check("reset.rgb", RGBOut, 8'h00);
    check_outs("reset", 2'b00, 1'b0);
    step(2);
    resetN = 1'b1;
    step(1);

    // START pixel mux
    set_pix(1'b1, 8'hE0, 1'b0, 8'h00, 1'b0, 8'h00, 8'hE0);
    set_pix(1'b0, 8'hE0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h03);
    set_pix(1'b0, 8'hE0, 1'b1, 8'h1C, 1'b1, 8'hFF, 8'h03);
    set_pix(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h03);

    // Lockout: press at frame 5 is discarded
    frames(5);
    press_key();
    check_outs("lockout5", 2'b00, 1'b0);
    release_key();
    check_outs("lockout5.rel", 2'b00, 1'b0);

    // Press at frame 31 is accepted, one clock after the synced edge
    frames(26);
    startKey = 1'b1;
    step(2);
    check_outs("start.pre", 2'b00, 1'b0);
    step(1);
    check_outs("start.go", 2'b01, 1'b1);

    // GAME pixel mux ignores start screen and overlay
    set_pix(1'b1, 8'hE0, 1'b1, 8'h1C, 1'b0, 8'h00, 8'h1C);
    set_pix(1'b1, 8'hE0, 1'b0, 8'h1C, 1'b1, 8'hFF, 8'h03);

    // Held key for 100 frames does nothing in GAME
    frames(100);
    check_outs("game.hold", 2'b01, 1'b1);

    // playerDead and keyRise in the same cycle: game lost wins
    release_key();
    startKey = 1'b1;
    step(2);
    playerDead = 1'b1;
    step(1);
    playerDead = 1'b0;
    check_outs("game.lost", 2'b10, 1'b0);
    release_key();

    // GAME_OVER overlay over frozen game
    set_pix(1'b0, 8'h00, 1'b1, 8'h1C, 1'b1, 8'hFF, 8'hFF);
    set_pix(1'b0, 8'h00, 1'b1, 8'h1C, 1'b0, 8'hFF, 8'h1C);
    set_pix(1'b1, 8'hE0, 1'b0, 8'h1C, 1'b0, 8'hFF, 8'h03);

    // Events ignored during GAME_OVER
    invadersReachedBottom = 1'b1;
    step(1);
    invadersReachedBottom = 1'b0;
    press_key();
    check_outs("over.ignore", 2'b10, 1'b0);
    release_key();

    // Exactly 4 frame pulses return to START
    frames(3);
    check_outs("over.f3", 2'b10, 1'b0);
    frames(1);
    check_outs("over.f4", 2'b00, 1'b0);

    // Lockout after return: frame 1 and frame 29 rejected, frame 30 accepted
    frames(1);
    press_key();
    check_outs("relock.f1", 2'b00, 1'b0);
    release_key();
    frames(28);
    press_key();
    check_outs("relock.f29", 2'b00, 1'b0);
    release_key();
    frames(1);
    press_key();
    check_outs("relock.f30", 2'b01, 1'b1);

    // Asynchronous reset in the middle of GAME
    set_pix(1'b0, 8'h00, 1'b1, 8'h1C, 1'b0, 8'h00, 8'h1C);
    #2 resetN = 1'b0;
    #1;
    check("areset.rgb", RGBOut, 8'h00);
    check_outs("areset", 2'b00, 1'b0);
    step(2);
    resetN = 1'b1;
    step(1);
    release_key();
    press_key();
    check_outs("areset.lock", 2'b00, 1'b0);
    release_key();

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
